compute_initiator: RTL
======================

Name: compute_initiator

Overview:
- Requester-side controller for the weighted-sum compute block in the tracking datapath.
- Accepts one candidate triple (weight/index pairs A, B, C) plus a selection threshold through a valid/ready handshake.
- Drives the compute block's start/operand interface, waits for its finish pulse, and latches the cumulative sums A, AB and ABC.
- Performs roulette selection of the candidate whose cumulative interval contains the threshold, then presents the index downstream with a valid/ready handshake.

Parameters:
W_LEN, 3, weight operand width
I_LEN, 4, index operand width
RES_W, 100, width of compute results and of the threshold
TIMEOUT, 16, max WAIT cycles for finish before abort (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_valid  in  1  upstream request valid
o_ready  out  1  ready to accept request
i_Aw / i_Bw / i_Cw  in  W_LEN each  candidate weights
i_Ai / i_Bi / i_Ci  in  I_LEN each  candidate indices
i_thresh  in  RES_W  selection threshold
o_start  out  1  start pulse to compute block
o_Aw / o_Bw / o_Cw  out  W_LEN each  operands to compute block
o_Ai / o_Bi / o_Ci  out  I_LEN each  operands to compute block
i_finish  in  1  compute finish strobe; results valid this cycle only
i_A / i_AB / i_ABC  in  RES_W each  cumulative results
o_valid  out  1  selection result valid
i_ready  in  1  downstream accepts result
o_sel  out  2  selected candidate: 0=A, 1=B, 2=C, 3=none
o_miss  out  1  threshold >= ABC (includes ABC==0); qualified by o_valid
o_timeout  out  1  one-cycle pulse: finish never arrived

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE; all operand, result and threshold registers 0; o_start=0, o_valid=0, o_sel=0, o_miss=0, o_timeout=0.
- o_ready is 1 only in IDLE.
- A reset asserted in any state aborts the operation immediately; no pulse is emitted after reset.

State machine:
- IDLE: when i_valid&&o_ready, latch the six operands and i_thresh, then go to ISSUE.
- ISSUE: o_start=1 for exactly one cycle; go to WAIT; clear the wait counter.
- WAIT:
  - If i_finish=1, capture i_A, i_AB and i_ABC, then go to SELECT.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no finish, pulse o_timeout for one cycle and go to IDLE. No result is produced.
  - If i_finish arrives in the same cycle as the timeout, finish wins.
- SELECT: unsigned compare of the latched threshold T:
  - T<A gives sel 0.
  - else T<AB gives sel 1.
  - else T<ABC gives sel 2.
  - else sel 3 with o_miss=1.
  - Register sel and miss, then go to DONE.
- DONE: o_valid=1; o_sel and o_miss are held stable. Go to IDLE on i_ready. While i_ready=0, stay in DONE.

Operand and interface rules:
- o_Aw..o_Ci are driven from the latched registers and are stable from ISSUE through WAIT. They are 0 after reset and retain their last value afterwards.
- i_finish outside WAIT is ignored.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

Latency and arithmetic:
- Latency with a 1-cycle-finish compute block: accept at cycle 0, o_start at cycle 1, finish/capture at cycle 2, SELECT at cycle 3, o_valid at cycle 4.
- Throughput is one request per 5 cycles minimum.
- Comparisons are unsigned on the full RES_W bits; no arithmetic is recomputed locally.
- A zero-width interval (A==0, or B==0 so that AB==A) is never selected.

Optional Feature:
- Macro COMPUTE_INITIATOR_STATS_EN.
- When defined:
  - Adds outputs o_hit_A, o_hit_B, o_hit_C and o_miss_cnt, each 16 bits.
  - Each counter increments by 1 in the DONE cycle that completes with i_ready for the matching selection.
  - Counters saturate at 16'hFFFF, reset to 0, and are unaffected by timeouts.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Aw=3,Ai=5, Bw=2,Bi=4, Cw=7,Ci=15, with a 1-cycle-finish model (A=15, AB=23, ABC=128):
  - thresh=10 gives sel=0.
  - thresh=15 gives sel=1.
  - thresh=22 gives sel=1.
  - thresh=23 gives sel=2.
  - thresh=127 gives sel=2.
  - thresh=128 gives sel=3, o_miss=1.
  - o_valid asserts at cycle 4 after accept in every case.
- All weights 0, thresh=0 -> ABC=0; sel=3, o_miss=1.
- Tie i_finish=0 -> o_start pulses once; o_timeout pulses exactly once, TIMEOUT cycles after entering WAIT; o_valid never asserts; o_ready returns to 1 the next cycle.
- Hold i_ready=0 for 5 cycles in DONE -> o_valid, o_sel and o_miss are held; o_ready=0; a new i_valid is not accepted until the cycle after the i_ready handshake.
- Assert i_rst_n=0 during WAIT -> all outputs are 0 and state is IDLE at once; a late i_finish after release is ignored and no o_valid is produced.
- With COMPUTE_INITIATOR_STATS_EN, run 3 requests with sels 0,2,3 -> o_hit_A=1, o_hit_B=0, o_hit_C=1, o_miss_cnt=1.

Source files
------------

// File: rtl/compute_initiator.sv
// Requester-side controller: issues one weighted-sum job, waits for finish, roulette-selects A/B/C.
// Optional hit/miss statistics counters are enabled by defining COMPUTE_INITIATOR_STATS_EN.
module compute_initiator #(
  parameter int W_LEN   = 3,
  parameter int I_LEN   = 4,
  parameter int RES_W   = 100,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W_LEN-1:0] i_Aw,
  input  logic [W_LEN-1:0] i_Bw,
  input  logic [W_LEN-1:0] i_Cw,
  input  logic [I_LEN-1:0] i_Ai,
  input  logic [I_LEN-1:0] i_Bi,
  input  logic [I_LEN-1:0] i_Ci,
  input  logic [RES_W-1:0] i_thresh,
  output logic             o_start,
  output logic [W_LEN-1:0] o_Aw,
  output logic [W_LEN-1:0] o_Bw,
  output logic [W_LEN-1:0] o_Cw,
  output logic [I_LEN-1:0] o_Ai,
  output logic [I_LEN-1:0] o_Bi,
  output logic [I_LEN-1:0] o_Ci,
  input  logic             i_finish,
  input  logic [RES_W-1:0] i_A,
  input  logic [RES_W-1:0] i_AB,
  input  logic [RES_W-1:0] i_ABC,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       o_sel,
  output logic             o_miss,
  output logic             o_timeout
`ifdef COMPUTE_INITIATOR_STATS_EN
  ,
  output logic [15:0]      o_hit_A,
  output logic [15:0]      o_hit_B,
  output logic [15:0]      o_hit_C,
  output logic [15:0]      o_miss_cnt
`endif
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SELECT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]    cnt_reg;
  logic [RES_W-1:0] thr_reg, a_reg, ab_reg, abc_reg;
  logic [W_LEN-1:0] aw_reg, bw_reg, cw_reg;
  logic [I_LEN-1:0] ai_reg, bi_reg, ci_reg;
  logic [1:0]       sel_reg, sel_next;
  logic             miss_reg, miss_next;
  logic             timeout_reg;
  logic             accept, capture, expire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_valid) begin
          accept     = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE:  state_next = S_WAIT;
      S_WAIT: begin
        // A finish landing on the last allowed cycle still counts.
        if (i_finish) begin
          capture    = 1'b1;
          state_next = S_SELECT;
        end else if (cnt_reg == CNT_LAST) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_SELECT: state_next = S_DONE;
      S_DONE:   if (i_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Strict less-than in order means zero-width intervals can never win.
  always_comb begin
    sel_next  = 2'd3;
    miss_next = 1'b1;
    if (thr_reg < a_reg) begin
      sel_next  = 2'd0;
      miss_next = 1'b0;
    end else if (thr_reg < ab_reg) begin
      sel_next  = 2'd1;
      miss_next = 1'b0;
    end else if (thr_reg < abc_reg) begin
      sel_next  = 2'd2;
      miss_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      aw_reg      <= '0;
      bw_reg      <= '0;
      cw_reg      <= '0;
      ai_reg      <= '0;
      bi_reg      <= '0;
      ci_reg      <= '0;
      thr_reg     <= '0;
      a_reg       <= '0;
      ab_reg      <= '0;
      abc_reg     <= '0;
      cnt_reg     <= '0;
      sel_reg     <= '0;
      miss_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= expire;
      if (accept) begin
        aw_reg  <= i_Aw;
        bw_reg  <= i_Bw;
        cw_reg  <= i_Cw;
        ai_reg  <= i_Ai;
        bi_reg  <= i_Bi;
        ci_reg  <= i_Ci;
        thr_reg <= i_thresh;
      end
      if (state_reg == S_ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == S_WAIT && !i_finish && !expire) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      if (capture) begin
        a_reg   <= i_A;
        ab_reg  <= i_AB;
        abc_reg <= i_ABC;
      end
      if (state_reg == S_SELECT) begin
        sel_reg  <= sel_next;
        miss_reg <= miss_next;
      end
    end
  end

  assign o_ready   = (state_reg == S_IDLE);
  assign o_start   = (state_reg == S_ISSUE);
  assign o_valid   = (state_reg == S_DONE);
  assign o_sel     = sel_reg;
  assign o_miss    = miss_reg;
  assign o_timeout = timeout_reg;
  assign o_Aw      = aw_reg;
  assign o_Bw      = bw_reg;
  assign o_Cw      = cw_reg;
  assign o_Ai      = ai_reg;
  assign o_Bi      = bi_reg;
  assign o_Ci      = ci_reg;

`ifdef COMPUTE_INITIATOR_STATS_EN
  // Counter gi tracks completed results with o_sel == gi (3 is the miss count).
  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_reg <= '0;
      end else if (state_reg == S_DONE && i_ready && sel_reg == 2'(gi) &&
                   cnt_reg != 16'hFFFF) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign o_hit_A    = g_stat[0].cnt_reg;
  assign o_hit_B    = g_stat[1].cnt_reg;
  assign o_hit_C    = g_stat[2].cnt_reg;
  assign o_miss_cnt = g_stat[3].cnt_reg;
`endif

endmodule
